// File: rtl/alu.sv
// Registered integer ALU: two unsigned operands, 4-bit function code, double-width result plus valid.
// Define ALU_DIV_EN to compile in the divider; otherwise function 0011 returns zero.
module alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     A,
  input  logic [DATA_WIDTH-1:0]     B,
  input  logic [3:0]                ALU_function,
  input  logic                      enable,
  output logic [2*DATA_WIDTH-1:0]   ALU_result,
  output logic                      ALU_result_valid
);

  localparam int RES_W = 2 * DATA_WIDTH;

  logic [RES_W-1:0]      a_ext;
  logic [RES_W-1:0]      b_ext;
  logic [RES_W-1:0]      result_nxt;
  logic [DATA_WIDTH-1:0] logic_lo;
  logic [RES_W-1:0]      result_p0;
  logic                  vld_p0;

  assign a_ext = {{DATA_WIDTH{1'b0}}, A};
  assign b_ext = {{DATA_WIDTH{1'b0}}, B};

  // Bitwise ops are evaluated at operand width so the upper half stays zero after inversion.
  always_comb begin
    logic_lo = '0;
    case (ALU_function)
      4'b0100: logic_lo = A & B;
      4'b0101: logic_lo = A | B;
      4'b0110: logic_lo = ~(A & B);
      4'b0111: logic_lo = ~(A | B);
      4'b1000: logic_lo = A ^ B;
      4'b1001: logic_lo = ~(A ^ B);
      default: logic_lo = '0;
    endcase
  end

  always_comb begin
    result_nxt = '0;
    case (ALU_function)
      4'b0000: result_nxt = a_ext + b_ext;
      4'b0001: result_nxt = a_ext - b_ext;
      4'b0010: result_nxt = a_ext * b_ext;
`ifdef ALU_DIV_EN
      4'b0011: result_nxt = (B == '0) ? '1 : (a_ext / b_ext);
`else
      4'b0011: result_nxt = '0;
`endif
      4'b0100, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001: result_nxt = {{DATA_WIDTH{1'b0}}, logic_lo};
      4'b1010: result_nxt = RES_W'(A == B);
      4'b1011: result_nxt = RES_W'(A > B);
      4'b1100: result_nxt = RES_W'(A < B);
      4'b1101: result_nxt = a_ext >> 1;
      4'b1110: result_nxt = a_ext << 1;
      default: result_nxt = '0;
    endcase
  end

  // Stage p0: single output register; enable low holds the result and drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p0 <= '0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= enable;
      if (enable) result_p0 <= result_nxt;
    end
  end

  assign ALU_result       = result_p0;
  assign ALU_result_valid = vld_p0;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven self-checking bench for alu at DATA_WIDTH=8.
// Expected divide results follow ALU_DIV_EN so the bench matches either build.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  ALU_function;
  logic        enable;
  logic [15:0] ALU_result;
  logic        ALU_result_valid;

  int total;
  int bad;

  alu #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .B(B),
    .ALU_function(ALU_function),
    .enable(enable),
    .ALU_result(ALU_result),
    .ALU_result_valid(ALU_result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  fn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] got_r, input logic [15:0] exp_r,
                       input logic got_v, input logic exp_v);
    total++;
    if (got_r !== exp_r || got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: result=%h valid=%b, required result=%h valid=%b",
               name, got_r, got_v, exp_r, exp_v);
    end
  endtask

  // Drive on the falling edge, let one rising edge register, sample 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic [3:0] fn,
                      input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    reset        = rst;
    enable       = en;
    ALU_function = fn;
    A            = a;
    B            = b;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string n, input logic [3:0] f, input logic [7:0] a,
                              input logic [7:0] b, input logic [15:0] e);
    vec_t v;
    v.name = n; v.fn = f; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [15:0] div_exp;
    logic [15:0] div0_exp;
    total = 0;
    bad   = 0;
    reset = 1'b1; enable = 1'b0; ALU_function = 4'h0; A = '0; B = '0;

`ifdef ALU_DIV_EN
    div_exp  = 16'h0002;
    div0_exp = 16'hFFFF;
`else
    div_exp  = 16'h0000;
    div0_exp = 16'h0000;
`endif

    vecs.push_back(mk("add",        4'b0000, 8'h54, 8'h2A, 16'h007E));
    vecs.push_back(mk("sub",        4'b0001, 8'h54, 8'h2A, 16'h002A));
    vecs.push_back(mk("mul",        4'b0010, 8'h54, 8'h2A, 16'h0DC8));
    vecs.push_back(mk("div",        4'b0011, 8'h54, 8'h2A, div_exp));
    vecs.push_back(mk("and",        4'b0100, 8'h54, 8'h2F, 16'h0004));
    vecs.push_back(mk("or",         4'b0101, 8'hF4, 8'h2C, 16'h00FC));
    vecs.push_back(mk("xor",        4'b1000, 8'hF4, 8'h2C, 16'h00D8));
    vecs.push_back(mk("nand",       4'b0110, 8'hF4, 8'h2C, 16'h00DB));
    vecs.push_back(mk("nor",        4'b0111, 8'hF4, 8'h2C, 16'h0003));
    vecs.push_back(mk("xnor",       4'b1001, 8'hF4, 8'h2C, 16'h0027));
    vecs.push_back(mk("sub_wrap",   4'b0001, 8'h2A, 8'h54, 16'hFFD6));
    vecs.push_back(mk("add_max",    4'b0000, 8'hFF, 8'hFF, 16'h01FE));
    vecs.push_back(mk("mul_max",    4'b0010, 8'hFF, 8'hFF, 16'hFE01));
    vecs.push_back(mk("shl_msb",    4'b1110, 8'h80, 8'h00, 16'h0100));
    vecs.push_back(mk("shr",        4'b1101, 8'h81, 8'h00, 16'h0040));
    vecs.push_back(mk("div_zero",   4'b0011, 8'h54, 8'h00, div0_exp));
    vecs.push_back(mk("eq_true",    4'b1010, 8'h33, 8'h33, 16'h0001));
    vecs.push_back(mk("gt_equal",   4'b1011, 8'h33, 8'h33, 16'h0000));
    vecs.push_back(mk("lt_true",    4'b1100, 8'h10, 8'h20, 16'h0001));
    vecs.push_back(mk("gt_true",    4'b1011, 8'hFF, 8'h00, 16'h0001));
    vecs.push_back(mk("eq_false",   4'b1010, 8'h10, 8'h20, 16'h0000));
    vecs.push_back(mk("reserved",   4'b1111, 8'hFF, 8'hFF, 16'h0000));

    // Reset wins over enable with live operands.
    step(1'b1, 1'b1, 4'b0000, 8'hFF, 8'hFF);
    check("reset", ALU_result, 16'h0000, ALU_result_valid, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 8'hFF, 8'hFF);
    check("post_reset_idle", ALU_result, 16'h0000, ALU_result_valid, 1'b0);

    // Back-to-back with enable held high: a new result every edge.
    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].fn, vecs[i].a, vecs[i].b);
      check(vecs[i].name, ALU_result, vecs[i].exp, ALU_result_valid, 1'b1);
    end

    // Enable gating: result holds, valid drops, then resumes.
    step(1'b0, 1'b1, 4'b0000, 8'h54, 8'h2A);
    check("gate_add", ALU_result, 16'h007E, ALU_result_valid, 1'b1);
    step(1'b0, 1'b0, 4'b0010, 8'hFF, 8'hFF);
    check("gate_hold1", ALU_result, 16'h007E, ALU_result_valid, 1'b0);
    step(1'b0, 1'b0, 4'b0001, 8'h01, 8'h02);
    check("gate_hold2", ALU_result, 16'h007E, ALU_result_valid, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 8'hFF, 8'hFF);
    check("gate_resume", ALU_result, 16'hFE01, ALU_result_valid, 1'b1);

    // Reset mid-stream discards the operation presented on that edge.
    step(1'b1, 1'b1, 4'b0000, 8'h12, 8'h34);
    check("mid_reset", ALU_result, 16'h0000, ALU_result_valid, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 8'h12, 8'h34);
    check("after_mid_reset", ALU_result, 16'h0046, ALU_result_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
